// File: rtl/axis_pkt_bram_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : axis_pkt_bram_writer_if
// Description : Stream, BRAM-write, descriptor and release signals of the
//               packet-to-BRAM writer, with master (source) and slave (DUT)
//               views.
// Revision    : 1.0 - initial release
// ============================================================================
interface axis_pkt_bram_writer_if #(
    parameter int data_width    = 512,
    parameter int keep_width    = data_width / 8,
    parameter int counter_width = 10
);
    logic                     t_valid;
    logic [data_width-1:0]    t_data;
    logic [keep_width-1:0]    t_keep;
    logic                     t_last;
    logic                     t_ready;

    logic                     bram_ena;
    logic [keep_width-1:0]    bram_wena;
    logic [counter_width-1:0] bram_address;
    logic [data_width-1:0]    bram_data;

    logic                     desc_valid;
    logic                     desc_ready;
    logic [counter_width-1:0] desc_addr;
    logic [counter_width:0]   desc_beats;
    logic [keep_width-1:0]    desc_last_keep;

    logic                     rel_valid;
    logic [counter_width:0]   rel_beats;
    logic [counter_width:0]   fill_level;
    logic                     rel_err;

    modport master (
        output t_valid, t_data, t_keep, t_last,
        input  t_ready,
        input  bram_ena, bram_wena, bram_address, bram_data,
        input  desc_valid, desc_addr, desc_beats, desc_last_keep,
        output desc_ready,
        output rel_valid, rel_beats,
        input  fill_level, rel_err
    );

    modport slave (
        input  t_valid, t_data, t_keep, t_last,
        output t_ready,
        output bram_ena, bram_wena, bram_address, bram_data,
        output desc_valid, desc_addr, desc_beats, desc_last_keep,
        input  desc_ready,
        input  rel_valid, rel_beats,
        output fill_level, rel_err
    );
endinterface
`default_nettype wire

// File: rtl/axis_pkt_bram_writer.sv
`default_nettype none
// ============================================================================
// Module      : axis_pkt_bram_writer
// Description : Writes AXI-Stream packets into a circular BRAM buffer and
//               emits one descriptor per packet; space is returned by release.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_pkt_bram_writer #(
    parameter int data_width     = 512,
    parameter int keep_width     = data_width / 8,
    parameter int counter_width  = 10,
    parameter int mem_size_depth = 1024
) (
    input wire logic              axis_clk,
    input wire logic              reset,
    axis_pkt_bram_writer_if.slave bus
);
    localparam logic [counter_width-1:0] c_last_addr = counter_width'(mem_size_depth - 1);
    localparam logic [counter_width:0]   c_depth     = (counter_width + 1)'(mem_size_depth);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DESC = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [counter_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [counter_width-1:0] start_addr_q, start_addr_d;
    logic [counter_width:0]   beat_cnt_q, beat_cnt_d;
    logic [counter_width:0]   fill_q, fill_d;
    logic                     rel_err_q, rel_err_d;
    logic                     bram_ena_q, bram_ena_d;
    logic [keep_width-1:0]    bram_wena_q, bram_wena_d;
    logic [counter_width-1:0] bram_address_q, bram_address_d;
    logic [data_width-1:0]    bram_data_q, bram_data_d;
    logic [counter_width-1:0] desc_addr_q, desc_addr_d;
    logic [counter_width:0]   desc_beats_q, desc_beats_d;
    logic [keep_width-1:0]    desc_last_keep_q, desc_last_keep_d;

    logic                     t_ready;
    logic                     accept;
    logic [counter_width:0]   fill_avail;

    always_comb begin
        t_ready = !reset && (state_q != DESC) && (fill_q < c_depth);
        accept  = bus.t_valid && t_ready;
    end

    always_comb begin
        state_d          = state_q;
        wr_ptr_d         = wr_ptr_q;
        start_addr_d     = start_addr_q;
        beat_cnt_d       = beat_cnt_q;
        bram_ena_d       = 1'b0;
        bram_wena_d      = '0;
        bram_address_d   = bram_address_q;
        bram_data_d      = bram_data_q;
        desc_addr_d      = desc_addr_q;
        desc_beats_d     = desc_beats_q;
        desc_last_keep_d = desc_last_keep_q;

        if (accept) begin
            bram_ena_d     = 1'b1;
            bram_wena_d    = bus.t_keep;
            bram_address_d = wr_ptr_q;
            bram_data_d    = bus.t_data;
            wr_ptr_d       = (wr_ptr_q == c_last_addr) ? '0 : wr_ptr_q + counter_width'(1);

            if (state_q == IDLE) begin
                start_addr_d = wr_ptr_q;
                beat_cnt_d   = (counter_width + 1)'(1);
            end else begin
                beat_cnt_d   = beat_cnt_q + (counter_width + 1)'(1);
            end

            // A single-beat packet has not latched its start address yet.
            if (bus.t_last) begin
                state_d          = DESC;
                desc_addr_d      = (state_q == IDLE) ? wr_ptr_q : start_addr_q;
                desc_beats_d     = beat_cnt_d;
                desc_last_keep_d = bus.t_keep;
            end else begin
                state_d = RECV;
            end
        end

        if ((state_q == DESC) && bus.desc_ready) begin
            state_d = IDLE;
        end
    end

    // The beat accepted this cycle counts as occupancy that may be released.
    always_comb begin
        fill_avail = fill_q + (counter_width + 1)'(accept);
        fill_d     = fill_avail;
        rel_err_d  = rel_err_q;
        if (bus.rel_valid) begin
            if (bus.rel_beats > fill_avail) begin
                fill_d    = '0;
                rel_err_d = 1'b1;
            end else begin
                fill_d = fill_avail - bus.rel_beats;
            end
        end
    end

    always_ff @(posedge axis_clk) begin
        if (reset) begin
            state_q          <= IDLE;
            wr_ptr_q         <= '0;
            start_addr_q     <= '0;
            beat_cnt_q       <= '0;
            fill_q           <= '0;
            rel_err_q        <= 1'b0;
            bram_ena_q       <= 1'b0;
            bram_wena_q      <= '0;
            bram_address_q   <= '0;
            bram_data_q      <= '0;
            desc_addr_q      <= '0;
            desc_beats_q     <= '0;
            desc_last_keep_q <= '0;
        end else begin
            state_q          <= state_d;
            wr_ptr_q         <= wr_ptr_d;
            start_addr_q     <= start_addr_d;
            beat_cnt_q       <= beat_cnt_d;
            fill_q           <= fill_d;
            rel_err_q        <= rel_err_d;
            bram_ena_q       <= bram_ena_d;
            bram_wena_q      <= bram_wena_d;
            bram_address_q   <= bram_address_d;
            bram_data_q      <= bram_data_d;
            desc_addr_q      <= desc_addr_d;
            desc_beats_q     <= desc_beats_d;
            desc_last_keep_q <= desc_last_keep_d;
        end
    end

    // Strobes are masked while reset is high so a write registered just
    // before reset never reaches the BRAM.
    assign bus.t_ready        = t_ready;
    assign bus.bram_ena       = bram_ena_q && !reset;
    assign bus.bram_wena      = reset ? '0 : bram_wena_q;
    assign bus.bram_address   = bram_address_q;
    assign bus.bram_data      = bram_data_q;
    assign bus.desc_valid     = (state_q == DESC) && !reset;
    assign bus.desc_addr      = desc_addr_q;
    assign bus.desc_beats     = desc_beats_q;
    assign bus.desc_last_keep = desc_last_keep_q;
    assign bus.fill_level     = fill_q;
    assign bus.rel_err        = rel_err_q;
endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_bram_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_pkt_bram_writer
// Description : Scoreboard bench for axis_pkt_bram_writer (depth 1024 and 6).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_pkt_bram_writer;
    localparam int DW     = 64;
    localparam int KW     = 8;
    localparam int CW     = 10;
    localparam int DEPTH  = 1024;
    localparam int CW6    = 3;
    localparam int DEPTH6 = 6;

    logic clk = 1'b0;
    logic reset;
    logic reset6;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    bit   done6 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axis_pkt_bram_writer_if #(.data_width(DW), .keep_width(KW), .counter_width(CW))  bus();
    axis_pkt_bram_writer_if #(.data_width(DW), .keep_width(KW), .counter_width(CW6)) bus6();

    axis_pkt_bram_writer #(
        .data_width(DW), .keep_width(KW), .counter_width(CW), .mem_size_depth(DEPTH)
    ) u_dut (
        .axis_clk (clk),
        .reset    (reset),
        .bus      (bus.slave)
    );

    axis_pkt_bram_writer #(
        .data_width(DW), .keep_width(KW), .counter_width(CW6), .mem_size_depth(DEPTH6)
    ) u_dut6 (
        .axis_clk (clk),
        .reset    (reset6),
        .bus      (bus6.slave)
    );

    typedef struct {
        logic [CW-1:0] addr;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        int            due;
    } wr_exp_t;

    typedef struct {
        logic [CW-1:0] addr;
        logic [CW:0]   beats;
        logic [KW-1:0] keep;
    } desc_exp_t;

    wr_exp_t   wr_q[$];
    desc_exp_t desc_q[$];
    wr_exp_t   mon_w;
    desc_exp_t mon_d;
    int        w6_addr[$];

    // reference model state
    int            m_ptr = 0;
    int            m_fill = 0;
    int            m_beats = 0;
    logic [CW-1:0] m_start = '0;
    bit            m_in_pkt = 1'b0;
    bit            m_desc = 1'b0;
    bit            m_err = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        check_eq("rst_pending_writes", 64'(wr_q.size()), 64'd0);
        wr_q.delete();
        desc_q.delete();
        m_ptr = 0; m_fill = 0; m_beats = 0; m_start = '0;
        m_in_pkt = 1'b0; m_desc = 1'b0; m_err = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_t_ready"},        64'(bus.t_ready),        64'd0);
        check_eq({tag, "_bram_ena"},       64'(bus.bram_ena),       64'd0);
        check_eq({tag, "_bram_wena"},      64'(bus.bram_wena),      64'd0);
        check_eq({tag, "_bram_address"},   64'(bus.bram_address),   64'd0);
        check_eq({tag, "_bram_data"},      64'(bus.bram_data),      64'd0);
        check_eq({tag, "_desc_valid"},     64'(bus.desc_valid),     64'd0);
        check_eq({tag, "_desc_addr"},      64'(bus.desc_addr),      64'd0);
        check_eq({tag, "_desc_beats"},     64'(bus.desc_beats),     64'd0);
        check_eq({tag, "_desc_last_keep"}, 64'(bus.desc_last_keep), 64'd0);
        check_eq({tag, "_fill_level"},     64'(bus.fill_level),     64'd0);
        check_eq({tag, "_rel_err"},        64'(bus.rel_err),        64'd0);
    endtask

    // One clock of stimulus; the model predicts ready, fill and descriptor
    // state and queues the BRAM write / descriptor an accepted beat implies.
    task automatic drive_cycle(input bit v, input logic [DW-1:0] d, input logic [KW-1:0] k,
                               input bit last, input bit rv, input int rb, input bit dr,
                               output bit acc);
        bit exp_rdy;
        bus.t_valid    = v;
        bus.t_data     = d;
        bus.t_keep     = k;
        bus.t_last     = last;
        bus.rel_valid  = rv;
        bus.rel_beats  = (CW + 1)'(rb);
        bus.desc_ready = dr;
        @(negedge clk);
        exp_rdy = !m_desc && (m_fill < DEPTH);
        check_eq("t_ready",    64'(bus.t_ready),    64'(exp_rdy));
        check_eq("fill_level", 64'(bus.fill_level), 64'(m_fill));
        check_eq("desc_valid", 64'(bus.desc_valid), 64'(m_desc));
        check_eq("rel_err",    64'(bus.rel_err),    64'(m_err));
        acc = v && exp_rdy;
        if (acc) begin
            wr_q.push_back('{addr: CW'(m_ptr), data: d, keep: k, due: cyc + 1});
            if (!m_in_pkt) begin
                m_start = CW'(m_ptr);
                m_beats = 1;
            end else begin
                m_beats++;
            end
            m_ptr = (m_ptr + 1) % DEPTH;
            m_fill++;
            if (last) begin
                desc_q.push_back('{addr: m_start, beats: (CW + 1)'(m_beats), keep: k});
                m_in_pkt = 1'b0;
                m_desc   = 1'b1;
            end else begin
                m_in_pkt = 1'b1;
            end
        end else if (m_desc && dr) begin
            m_desc = 1'b0;
        end
        if (rv) begin
            if (rb > m_fill) begin
                m_fill = 0;
                m_err  = 1'b1;
            end else begin
                m_fill -= rb;
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (bus.bram_ena) begin
            if (wr_q.size() == 0) begin
                check_eq("wr_unexpected", 64'(bus.bram_ena), 64'd0);
            end else begin
                mon_w = wr_q.pop_front();
                check_eq("wr_addr",    64'(bus.bram_address), 64'(mon_w.addr));
                check_eq("wr_data",    bus.bram_data,         mon_w.data);
                check_eq("wr_wena",    64'(bus.bram_wena),    64'(mon_w.keep));
                check_eq("wr_latency", 64'(cyc),              64'(mon_w.due));
            end
        end
        if (bus.desc_valid && bus.desc_ready) begin
            if (desc_q.size() == 0) begin
                check_eq("desc_unexpected", 64'(bus.desc_valid), 64'd0);
            end else begin
                mon_d = desc_q.pop_front();
                check_eq("desc_addr",      64'(bus.desc_addr),      64'(mon_d.addr));
                check_eq("desc_beats",     64'(bus.desc_beats),     64'(mon_d.beats));
                check_eq("desc_last_keep", 64'(bus.desc_last_keep), 64'(mon_d.keep));
            end
        end
        if (bus6.bram_ena) w6_addr.push_back(int'(bus6.bram_address));
    end

    initial begin : p_main
        bit acc;
        int n_acc;
        int waited;
        reset = 1'b1;
        bus.t_valid = 1'b0; bus.t_data = '0; bus.t_keep = '0; bus.t_last = 1'b0;
        bus.desc_ready = 1'b0; bus.rel_valid = 1'b0; bus.rel_beats = '0;
        @(negedge clk);
        @(negedge clk);
        check_reset_state("por");
        @(posedge clk);
        #1 reset = 1'b0;

        // 4-beat packet, descriptor held off for 5 cycles
        for (int i = 0; i < 4; i++)
            drive_cycle(1'b1, {32'hA5A5_0000 + 32'(i), $urandom}, (i == 3) ? 8'h0F : 8'hFF,
                        i == 3, 1'b0, 0, 1'b0, acc);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 64'hDEAD_0000_0000_0000, 8'hFF, 1'b0, 1'b0, 0, 1'b0, acc);
            check_eq("hold_desc_valid", 64'(bus.desc_valid),     64'd1);
            check_eq("hold_desc_addr",  64'(bus.desc_addr),      64'd0);
            check_eq("hold_desc_beats", 64'(bus.desc_beats),     64'd4);
            check_eq("hold_desc_keep",  64'(bus.desc_last_keep), 64'h0F);
        end
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 0, 1'b1, acc);

        // 3-beat packet with a zero-keep middle beat, consumer always ready
        for (int i = 0; i < 3; i++)
            drive_cycle(1'b1, {32'hB0B0_0000 + 32'(i), $urandom}, (i == 1) ? 8'h00 : 8'hFF,
                        i == 2, 1'b0, 0, 1'b1, acc);
        check_eq("pkt2_desc_addr", 64'(bus.desc_addr), 64'd4);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 0, 1'b1, acc);

        // simultaneous accept and release, then over-release
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, m_fill, 1'b0, acc);
        for (int i = 0; i < 10; i++)
            drive_cycle(1'b1, {32'hC0C0_0000 + 32'(i), $urandom}, 8'hFF, 1'b0, 1'b0, 0, 1'b0, acc);
        drive_cycle(1'b1, 64'h1234_5678_9ABC_DEF0, 8'h3F, 1'b1, 1'b1, 3, 1'b0, acc);
        check_eq("fill_acc_rel", 64'(bus.fill_level), 64'd8);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, 3, 1'b1, acc);
        check_eq("fill_rel3", 64'(bus.fill_level), 64'd5);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, 20, 1'b0, acc);
        check_eq("fill_over_rel", 64'(bus.fill_level), 64'd0);
        check_eq("rel_err_set",   64'(bus.rel_err),    64'd1);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 0, 1'b0, acc);

        // reset during beat 2 of a packet
        drive_cycle(1'b1, 64'hEEEE_0000_0000_0001, 8'hFF, 1'b0, 1'b0, 0, 1'b0, acc);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 0, 1'b0, acc);
        bus.t_valid = 1'b1; bus.t_data = 64'hEEEE_0000_0000_0002; bus.t_last = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_t_ready",  64'(bus.t_ready),  64'd0);
        check_eq("rst_mid_bram_ena", 64'(bus.bram_ena), 64'd0);
        @(negedge clk);
        check_reset_state("mid");
        @(posedge clk);
        #1 reset = 1'b0;
        bus.t_valid = 1'b0;
        model_reset();
        drive_cycle(1'b1, 64'hF00D_0000_0000_0000, 8'hFF, 1'b0, 1'b0, 0, 1'b1, acc);
        drive_cycle(1'b1, 64'hF00D_0000_0000_0001, 8'h01, 1'b1, 1'b0, 0, 1'b1, acc);
        check_eq("post_rst_desc_addr", 64'(bus.desc_addr), 64'd0);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, m_fill, 1'b1, acc);

        // fill to capacity, then release one beat
        n_acc = 0;
        for (int i = 0; i < 1030; i++) begin
            drive_cycle(1'b1, {32'(i), 32'hC0DE_0000}, 8'hFF, 1'b0, 1'b0, 0, 1'b0, acc);
            n_acc += int'(acc);
        end
        check_eq("full_accepts", 64'(n_acc),          64'd1024);
        check_eq("full_fill",    64'(bus.fill_level), 64'd1024);
        check_eq("full_t_ready", 64'(bus.t_ready),    64'd0);
        drive_cycle(1'b1, 64'h5555_0000_0000_0000, 8'hFF, 1'b0, 1'b1, 1, 1'b0, acc);
        n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, {32'h7777_0000 + 32'(i), 32'h0}, 8'hFF, 1'b0, 1'b0, 0, 1'b0, acc);
            n_acc += int'(acc);
        end
        check_eq("after_rel1_accepts", 64'(n_acc), 64'd1);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, 1024, 1'b0, acc);
        drive_cycle(1'b1, 64'h9999_0000_0000_0000, 8'h80, 1'b1, 1'b0, 0, 1'b0, acc);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 0, 1'b1, acc);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 0, 1'b0, acc);

        waited = 0;
        while (!done6 && waited < 500) begin
            @(posedge clk);
            waited++;
        end
        check_eq("dut6_done", 64'(done6), 64'd1);
        check_eq("wr_q_drained",   64'(wr_q.size()),   64'd0);
        check_eq("desc_q_drained", 64'(desc_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Depth-6 buffer: the second packet wraps 4,5,0,1.
    initial begin : p_dut6
        int waited;
        int exp6[8];
        exp6 = '{0, 1, 2, 3, 4, 5, 0, 1};
        reset6 = 1'b1;
        bus6.t_valid = 1'b0; bus6.t_data = '0; bus6.t_keep = '0; bus6.t_last = 1'b0;
        bus6.desc_ready = 1'b0; bus6.rel_valid = 1'b0; bus6.rel_beats = '0;
        repeat (3) @(posedge clk);
        #1 reset6 = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < 4; b++) begin
                bus6.t_valid = 1'b1;
                bus6.t_data  = 64'(p * 16 + b);
                bus6.t_keep  = '1;
                bus6.t_last  = (b == 3);
                waited = 0;
                @(negedge clk);
                while (!bus6.t_ready && waited < 20) begin
                    waited++;
                    @(negedge clk);
                end
                if (waited >= 20) check_eq("d6_accept_timeout", 64'(bus6.t_ready), 64'd1);
                @(posedge clk);
                #1;
            end
            bus6.t_valid    = 1'b0;
            bus6.desc_ready = 1'b1;
            waited = 0;
            @(negedge clk);
            while (!bus6.desc_valid && waited < 20) begin
                waited++;
                @(negedge clk);
            end
            check_eq("d6_desc_valid", 64'(bus6.desc_valid), 64'd1);
            check_eq("d6_desc_addr",  64'(bus6.desc_addr),  (p == 0) ? 64'd0 : 64'd4);
            check_eq("d6_desc_beats", 64'(bus6.desc_beats), 64'd4);
            @(posedge clk);
            #1 bus6.desc_ready = 1'b0;
            if (p == 0) begin
                bus6.rel_valid = 1'b1;
                bus6.rel_beats = 4'd4;
                @(posedge clk);
                #1 bus6.rel_valid = 1'b0;
            end
        end
        @(negedge clk);
        check_eq("d6_fill",     64'(bus6.fill_level), 64'd4);
        check_eq("d6_n_writes", 64'(w6_addr.size()),  64'd8);
        for (int i = 0; i < 8; i++)
            if (i < w6_addr.size()) check_eq("d6_wr_addr", 64'(w6_addr[i]), 64'(exp6[i]));
        done6 = 1'b1;
    end
endmodule
`default_nettype wire

// File: doc/axis_pkt_bram_writer.md
AXIS_PKT_BRAM_WRITER -- requirements
Module: axis_pkt_bram_writer

Interface
REQ-001 Parameter data_width, default 512: AXI-Stream data and BRAM data width in bits, multiple of 8.
REQ-002 Parameter keep_width, default data_width/8: byte-enable width.
REQ-003 Parameter counter_width, default 10: BRAM address width.
REQ-004 Parameter mem_size_depth, default 1024: BRAM depth in beats; need not be a power of two; at most 2^counter_width.
REQ-005 axis_clk  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 t_valid  input  1  stream beat valid.
REQ-008 t_data  input  data_width  stream beat data.
REQ-009 t_keep  input  keep_width  per-byte valid.
REQ-010 t_last  input  1  last beat of packet.
REQ-011 t_ready  output  1  beat can be accepted.
REQ-012 bram_ena  output  1  BRAM port enable.
REQ-013 bram_wena  output  keep_width  per-byte BRAM write enable.
REQ-014 bram_address  output  counter_width  BRAM write address.
REQ-015 bram_data  output  data_width  BRAM write data.
REQ-016 desc_valid  output  1  packet descriptor available.
REQ-017 desc_ready  input  1  consumer accepts descriptor.
REQ-018 desc_addr  output  counter_width  BRAM address of the packet's first beat.
REQ-019 desc_beats  output  counter_width+1  beat count of the packet.
REQ-020 desc_last_keep  output  keep_width  t_keep of the packet's last beat.
REQ-021 rel_valid  input  1  consumer frees buffer space.
REQ-022 rel_beats  input  counter_width+1  number of beats freed.
REQ-023 fill_level  output  counter_width+1  beats currently occupied.
REQ-024 rel_err  output  1  sticky flag: release exceeded occupancy.

Function
REQ-025 A beat is accepted in any cycle where t_valid=1 and t_ready=1.
REQ-026 t_ready = (state != DESC) and (fill_level < mem_size_depth), asserted combinationally, and 0 while reset=1.
REQ-027 FSM states are IDLE, RECV and DESC.
REQ-028 IDLE->RECV on an accepted beat with t_last=0; IDLE->DESC on an accepted beat with t_last=1; RECV->DESC on an accepted beat with t_last=1; DESC->IDLE when desc_ready=1; all other cases hold state.
REQ-029 An accepted beat drives, one cycle later: bram_ena=1, bram_wena=t_keep, bram_address=wr_ptr, bram_data=t_data; fixed latency is 1 cycle.
REQ-030 In cycles with no accepted beat, bram_ena=0 and bram_wena=0; bram_address and bram_data hold their previous values.
REQ-031 An accepted beat with t_keep=0 is still written (bram_ena=1, bram_wena=0) and counted in beats and fill.
REQ-032 wr_ptr increments on each accepted beat and wraps from mem_size_depth-1 to 0.
REQ-033 The first accepted beat in IDLE latches wr_ptr as the packet start address; the beat counter restarts at 1 on that beat.
REQ-034 On entry to DESC: desc_valid=1, desc_addr=start address, desc_beats=beat count including the last beat, desc_last_keep=last t_keep; these values are held stable until desc_ready=1.
REQ-035 desc_valid deasserts in the cycle after the handshake; a new packet may start in the cycle after the handshake.
REQ-036 fill_level adds 1 per accepted beat and subtracts rel_beats when rel_valid=1; both apply in the same cycle when simultaneous (net change).
REQ-037 If rel_beats exceeds the occupancy available to release that cycle, fill_level saturates at 0 and rel_err sets; rel_err stays set until reset.
REQ-038 When fill_level reaches mem_size_depth mid-packet, t_ready drops and the packet stalls; no data is dropped; acceptance resumes after a release.

Reset
REQ-039 While reset=1: state=IDLE, wr_ptr=0, fill_level=0, rel_err=0, t_ready=0, bram_ena=0, bram_wena=0, bram_address=0, bram_data=0, desc_valid=0, desc_addr=0, desc_beats=0, desc_last_keep=0.
REQ-040 Reset asserted mid-packet or during DESC discards the partial packet or pending descriptor, with no further BRAM write.

Verification
REQ-041 A 4-beat packet with t_keep all-ones and last t_keep=0x0F at addresses 0-3 -> four BRAM writes at addresses 0..3, each 1 cycle after its accept; desc_addr=0, desc_beats=4, desc_last_keep=0x0F.
REQ-042 desc_ready held 0 for 5 cycles after the descriptor asserts -> t_ready=0 and the descriptor fields stay stable for those 5 cycles; the next packet starts at address 4.
REQ-043 mem_size_depth=6, two 4-beat packets with a release of 4 beats between them -> the second packet is written at addresses 4,5,0,1 and desc_addr=4.
REQ-044 Continuous t_valid with no release -> after 1024 accepts, t_ready=0 and fill_level=1024; rel_valid with rel_beats=1 -> exactly one more beat is accepted.
REQ-045 Beat accepted in the same cycle as rel_valid with rel_beats=3 at fill_level=10 -> fill_level=8; rel_beats=20 at fill_level=5 -> fill_level=0 and rel_err=1.
REQ-046 Reset pulsed during beat 2 of a packet -> no BRAM write follows; outputs take their reset values; the next packet has desc_addr=0.
